// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU readout controller: FSM encoding,
// header field layout, flag bit positions and the queued trigger entry.
package tlu_pkg;

   // Controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_EMIT  = 2'd3;

   // Flag bit indices inside the 8-bit flags field
   localparam int FLAG_TIMEOUT = 0;
   localparam int FLAG_GAP     = 1;
   localparam int FLAG_OVF     = 2;

   // 64-bit header layout: id | flags | zero | timestamp
   localparam int HDR_ID_LSB    = 48;
   localparam int HDR_ID_W      = 16;
   localparam int HDR_FLAGS_LSB = 40;
   localparam int HDR_TS_LSB    = 0;
   localparam int HDR_TS_W      = 32;

   // One queued trigger: id, capture timestamp, gap flag, overflow-before flag
   typedef struct packed {
      logic [15:0] id;
      logic [31:0] ts;
      logic        gap;
      logic        ovf;
   } trig_entry_t;

   localparam int ENTRY_W = $bits(trig_entry_t);   // 50 bits

   // Saturating 16-bit increment used by the drop and timeout counters
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/tlu_trig_fifo.sv
// Synchronous FIFO for pending triggers. The caller only asserts push when
// there is room (or a pop happens in the same cycle) and pop when non-empty.
// Read data is registered on pop and held until the next pop.
module tlu_trig_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 50
) (
   input  logic                     CLK,
   input  logic                     RST_SYS,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;

   // Storage array, no reset so it maps onto block RAM
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr_reg] <= din;
   end

   // Registered read; on a full push+pop the old slot contents are read first
   always_ff @(posedge CLK or posedge RST_SYS) begin
      if (RST_SYS)  dout <= '0;
      else if (pop) dout <= mem[rd_ptr_reg];
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge CLK or posedge RST_SYS) begin
      if (RST_SYS) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/tlu_readout_ctrl.sv
// Trigger-driven readout sequencer: queues TLU triggers with a timestamp,
// launches and supervises one readout per trigger, emits a 64-bit header
// per event and drives the busy/veto back to the TLU handshake.
module tlu_readout_ctrl
   import tlu_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        CLK,
   input  logic        RST_SYS,
   input  logic        EN,
   input  logic        TRIG_VALID,
   input  logic [15:0] TRIG_ID,
   output logic        RO_START,
   input  logic        RO_DONE,
   output logic        HDR_VALID,
   input  logic        HDR_READY,
   output logic [63:0] HDR_DATA,
   output logic        DAQ_BUSY,
   output logic [15:0] OVF_CNT,
   output logic [15:0] TMO_CNT
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]         state_reg;
   logic [31:0]        ts_reg;
   logic [15:0]        prev_id_reg;
   logic               have_prev_reg;
   logic               ovf_sticky_reg;
   logic [15:0]        ovf_cnt_reg;
   logic [15:0]        tmo_cnt_reg;
   logic [TW-1:0]      wait_cnt_reg;
   logic [63:0]        hdr_data_reg;
   logic               daq_busy_reg;

   logic               trig_acc;
   logic               pop_en;
   logic               push_en;
   logic               gap;
   logic               tmo_hit;
   trig_entry_t        entry_in;
   trig_entry_t        head;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic [CW-1:0]      count_next;
   logic [63:0]        hdr_next;

   assign trig_acc = EN && TRIG_VALID;
   assign pop_en   = (state_reg == ST_IDLE) && EN && !fifo_empty;
   // A pop in the same cycle frees a slot, so a full queue still accepts
   assign push_en  = trig_acc && (!fifo_full || pop_en);
   assign gap      = have_prev_reg && (TRIG_ID != prev_id_reg + 16'd1);
   assign entry_in = {TRIG_ID, ts_reg, gap, ovf_sticky_reg};
   assign head     = fifo_dout;
   assign tmo_hit  = (state_reg == ST_WAIT) && !RO_DONE &&
                     (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
   assign count_next = fifo_count + CW'(push_en) - CW'(pop_en);

   tlu_trig_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .CLK     (CLK),
      .RST_SYS (RST_SYS),
      .push    (push_en),
      .din     (entry_in),
      .pop     (pop_en),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Header word for the event finishing in this WAIT cycle
   always_comb begin
      hdr_next = '0;
      hdr_next[HDR_ID_LSB +: HDR_ID_W]      = head.id;
      hdr_next[HDR_FLAGS_LSB + FLAG_TIMEOUT] = tmo_hit;
      hdr_next[HDR_FLAGS_LSB + FLAG_GAP]     = head.gap;
      hdr_next[HDR_FLAGS_LSB + FLAG_OVF]     = head.ovf;
      hdr_next[HDR_TS_LSB +: HDR_TS_W]      = head.ts;
   end

   // Free-running timestamp
   always_ff @(posedge CLK or posedge RST_SYS) begin
      if (RST_SYS) ts_reg <= '0;
      else         ts_reg <= ts_reg + 32'd1;
   end

   // Trigger bookkeeping: id continuity, drop counting, overflow marker
   always_ff @(posedge CLK or posedge RST_SYS) begin
      if (RST_SYS) begin
         prev_id_reg    <= '0;
         have_prev_reg  <= 1'b0;
         ovf_sticky_reg <= 1'b0;
         ovf_cnt_reg    <= '0;
      end else if (trig_acc) begin
         prev_id_reg   <= TRIG_ID;
         have_prev_reg <= 1'b1;
         if (push_en) begin
            ovf_sticky_reg <= 1'b0;
         end else begin
            ovf_sticky_reg <= 1'b1;
            ovf_cnt_reg    <= sat_inc16(ovf_cnt_reg);
         end
      end else if (!EN) begin
         have_prev_reg <= 1'b0;
      end
   end

   // Readout sequencing, timeout supervision and header capture
   always_ff @(posedge CLK or posedge RST_SYS) begin
      if (RST_SYS) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
         hdr_data_reg <= '0;
         tmo_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pop_en) state_reg <= ST_START;
            end
            ST_START: begin
               state_reg    <= ST_WAIT;
               wait_cnt_reg <= '0;
            end
            ST_WAIT: begin
               if (RO_DONE || tmo_hit) begin
                  state_reg    <= ST_EMIT;
                  hdr_data_reg <= hdr_next;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + TW'(1);
               end
               if (tmo_hit) tmo_cnt_reg <= sat_inc16(tmo_cnt_reg);
            end
            ST_EMIT: begin
               if (HDR_READY) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Veto when the queue is nearly full or the run is disabled
   always_ff @(posedge CLK or posedge RST_SYS) begin
      if (RST_SYS) daq_busy_reg <= 1'b1;
      else         daq_busy_reg <= (count_next >= CW'(FIFO_DEPTH - 1)) || !EN;
   end

   assign RO_START  = (state_reg == ST_START);
   assign HDR_VALID = (state_reg == ST_EMIT);
   assign HDR_DATA  = hdr_data_reg;
   assign DAQ_BUSY  = daq_busy_reg;
   assign OVF_CNT   = ovf_cnt_reg;
   assign TMO_CNT   = tmo_cnt_reg;

endmodule

// File: tb/tb_tlu_readout_ctrl.sv
// Bench for tlu_readout_ctrl: cycle-level reference model of queue, readout
// and counters; expected headers go to a scoreboard that an independent
// monitor drains on every header handshake.
module tb_tlu_readout_ctrl;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        CLK = 1'b0;
   logic        RST_SYS;
   logic        EN;
   logic        TRIG_VALID;
   logic [15:0] TRIG_ID;
   logic        RO_START;
   logic        RO_DONE;
   logic        HDR_VALID;
   logic        HDR_READY;
   logic [63:0] HDR_DATA;
   logic        DAQ_BUSY;
   logic [15:0] OVF_CNT;
   logic [15:0] TMO_CNT;

   int errors = 0;
   int checks = 0;

   tlu_readout_ctrl #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK        (CLK),
      .RST_SYS    (RST_SYS),
      .EN         (EN),
      .TRIG_VALID (TRIG_VALID),
      .TRIG_ID    (TRIG_ID),
      .RO_START   (RO_START),
      .RO_DONE    (RO_DONE),
      .HDR_VALID  (HDR_VALID),
      .HDR_READY  (HDR_READY),
      .HDR_DATA   (HDR_DATA),
      .DAQ_BUSY   (DAQ_BUSY),
      .OVF_CNT    (OVF_CNT),
      .TMO_CNT    (TMO_CNT)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] id;
      logic [31:0] ts;
      bit          gap;
      bit          ovf;
   } ent_t;

   ent_t        mq[$];        // pending triggers
   logic [63:0] exp_q[$];     // scoreboard of expected headers
   ent_t        m_cur;
   bit          m_launch, m_wait, m_present;
   int          m_wait_n;     // 1-based count of the current waiting cycle
   logic [31:0] m_ts;
   logic [15:0] m_prev;
   bit          m_have_prev, m_sticky, m_busy;
   int          m_ovf, m_tmo;

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_launch = 0; m_wait = 0; m_present = 0; m_wait_n = 0;
      m_ts = '0; m_prev = '0; m_have_prev = 0; m_sticky = 0;
      m_busy = 1; m_ovf = 0; m_tmo = 0;
   endtask

   task automatic model_emit(input bit to);
      m_wait = 0;
      m_present = 1;
      exp_q.push_back({m_cur.id, 5'b0, m_cur.ovf, m_cur.gap, to, 8'h00, m_cur.ts});
      if (to && m_tmo < 65535) m_tmo++;
   endtask

   // Advance the model across one clock edge given this cycle's inputs
   task automatic model_step(input bit en, input bit tv, input logic [15:0] id,
                             input bit done, input bit rdy);
      ent_t e;
      if (m_present) begin
         if (rdy) m_present = 0;
      end else if (m_wait) begin
         if (done)               model_emit(1'b0);
         else if (m_wait_n == TMO) model_emit(1'b1);
         else                    m_wait_n++;
      end else if (m_launch) begin
         m_launch = 0; m_wait = 1; m_wait_n = 1;
      end else if (en && mq.size() > 0) begin
         m_cur = mq.pop_front();
         m_launch = 1;
      end
      if (en && tv) begin
         if (mq.size() < DEPTH) begin
            e.id  = id;
            e.ts  = m_ts;
            e.gap = m_have_prev && (id != 16'(m_prev + 16'd1));
            e.ovf = m_sticky;
            mq.push_back(e);
            m_sticky = 0;
         end else begin
            if (m_ovf < 65535) m_ovf++;
            m_sticky = 1;
         end
         m_prev = id;
         m_have_prev = 1;
      end else if (!en) begin
         m_have_prev = 0;
      end
      m_busy = (mq.size() >= DEPTH - 1) || !en;
      m_ts = m_ts + 32'd1;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ro_start"},  64'(RO_START),  64'd0);
      check({tag, "_hdr_valid"}, 64'(HDR_VALID), 64'd0);
      check({tag, "_hdr_data"},  HDR_DATA,       64'd0);
      check({tag, "_ovf_cnt"},   64'(OVF_CNT),   64'd0);
      check({tag, "_tmo_cnt"},   64'(TMO_CNT),   64'd0);
      check({tag, "_daq_busy"},  64'(DAQ_BUSY),  64'd1);
   endtask

   // One clock cycle: drive inputs, advance model, compare after the edge
   task automatic cyc(input bit en, input bit tv, input logic [15:0] id,
                      input bit done, input bit rdy);
      EN = en; TRIG_VALID = tv; TRIG_ID = id; RO_DONE = done; HDR_READY = rdy;
      model_step(en, tv, id, done, rdy);
      @(posedge CLK);
      #1;
      check("ro_start",  64'(RO_START),  64'(m_launch));
      check("hdr_valid", 64'(HDR_VALID), 64'(m_present));
      check("daq_busy",  64'(DAQ_BUSY),  64'(m_busy));
      check("ovf_cnt",   64'(OVF_CNT),   64'(m_ovf));
      check("tmo_cnt",   64'(TMO_CNT),   64'(m_tmo));
      $display("cyc t=%0t en=%0b tv=%0b id=%0d done=%0b rdy=%0b -> ro_start=%0b hdr_valid=%0b busy=%0b ovf=%0d tmo=%0d",
               $time, en, tv, id, done, rdy, RO_START, HDR_VALID, DAQ_BUSY, OVF_CNT, TMO_CNT);
   endtask

   // ---------------- header monitor ----------------
   initial begin
      logic [63:0] last_hdr;
      bit          held;
      logic [63:0] exp;
      held = 0;
      last_hdr = '0;
      forever begin
         @(negedge CLK);
         if (RST_SYS || !HDR_VALID) begin
            held = 0;
         end else begin
            if (held) check("hdr_stable", HDR_DATA, last_hdr);
            if (HDR_READY) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL hdr_unexpected: got %h required no header", HDR_DATA);
               end else begin
                  exp = exp_q.pop_front();
                  check("hdr_data", HDR_DATA, exp);
                  $display("hdr id=%0d flags=%h ts=%0d", HDR_DATA[63:48], HDR_DATA[47:40], HDR_DATA[31:0]);
               end
               held = 0;
            end else begin
               held = 1;
               last_hdr = HDR_DATA;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] rid;
      RST_SYS = 1; EN = 0; TRIG_VALID = 0; TRIG_ID = '0; RO_DONE = 0; HDR_READY = 0;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check_reset("por");
      RST_SYS = 0;

      // single trigger, done mid-wait
      cyc(1, 1, 16'd5, 0, 1);
      repeat (6) cyc(1, 0, 16'd0, 0, 1);
      cyc(1, 0, 16'd0, 1, 1);
      repeat (4) cyc(1, 0, 16'd0, 0, 1);

      // downstream stall for >20 cycles with a second trigger queued
      cyc(1, 1, 16'd6, 0, 0);
      repeat (4) cyc(1, 0, 16'd0, 0, 0);
      cyc(1, 0, 16'd0, 1, 0);
      cyc(1, 1, 16'd7, 0, 0);
      repeat (22) cyc(1, 0, 16'd0, 0, 0);
      repeat (6) cyc(1, 0, 16'd0, 0, 1);
      repeat (12) cyc(1, 0, 16'd0, 1, 1);

      // disabled run ignores triggers, then ids 1,2,4
      cyc(0, 1, 16'd99, 0, 1);
      cyc(0, 0, 16'd0, 0, 1);
      cyc(1, 1, 16'd1, 0, 1);
      cyc(1, 1, 16'd2, 0, 1);
      cyc(1, 1, 16'd4, 0, 1);
      repeat (25) cyc(1, 0, 16'd0, 1, 1);

      // burst with readout stalled: fill, drop, time out
      for (int i = 0; i < 8; i++) cyc(1, 1, 16'(10 + i), 0, 1);
      repeat (60) cyc(1, 0, 16'd0, 0, 1);
      cyc(1, 1, 16'd18, 0, 1);
      repeat (20) cyc(1, 0, 16'd0, 1, 1);

      // done in the final wait cycle, then a true timeout
      cyc(1, 1, 16'd30, 0, 1);
      repeat (9) cyc(1, 0, 16'd0, 0, 1);
      cyc(1, 0, 16'd0, 1, 1);
      repeat (4) cyc(1, 0, 16'd0, 0, 1);
      cyc(1, 1, 16'd31, 0, 1);
      repeat (14) cyc(1, 0, 16'd0, 0, 1);

      // reset in the middle of a readout
      cyc(1, 1, 16'd40, 0, 1);
      repeat (4) cyc(1, 0, 16'd0, 0, 1);
      RST_SYS = 1; EN = 0; TRIG_VALID = 0; RO_DONE = 0; HDR_READY = 0;
      #1;
      check_reset("mid");
      model_reset();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check_reset("held");
      RST_SYS = 0;
      cyc(1, 1, 16'd41, 0, 1);
      repeat (5) cyc(1, 0, 16'd0, 0, 1);
      cyc(1, 0, 16'd0, 1, 1);
      repeat (4) cyc(1, 0, 16'd0, 0, 1);

      // randomized traffic
      rid = 16'd100;
      for (int i = 0; i < 800; i++) begin
         bit en, tv;
         en = ($urandom_range(0, 19) != 0);
         tv = ($urandom_range(0, 2) == 0);
         if (tv) rid = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(rid + 16'd1);
         cyc(en, tv, rid, $urandom_range(0, 6) == 0, $urandom_range(0, 2) != 0);
      end

      // drain
      repeat (40) cyc(1, 0, 16'd0, 1, 1);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
